// File: rtl/vga_plot_arbiter_if.sv
// Pixel-request bundle between the drawing engines and the plot arbiter, plus the
// registered pixel-write port toward the VGA adapter.
interface vga_plot_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_lock;
   logic [NUM_REQ*8-1:0] req_x;
   logic [NUM_REQ*7-1:0] req_y;
   logic [NUM_REQ*3-1:0] req_colour;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           vga_x;
   logic [6:0]           vga_y;
   logic [2:0]           vga_colour;
   logic                 vga_plot;

   modport master (
      output req_valid, req_lock, req_x, req_y, req_colour,
      input  req_ready, vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      input  req_valid, req_lock, req_x, req_y, req_colour,
      output req_ready, vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter for the VGA pixel-write port: accept -> plot in 1 cycle, req_ready is
// combinational and one-hot; optional burst lock. VGA_ARB_CLIP_EN drops off-screen pixels.
module vga_plot_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   vga_plot_arbiter_if.slave bus,
   output logic [2:0]        grant_id,
   output logic [CNT_W-1:0]  plot_count,
`ifdef VGA_ARB_CLIP_EN
   output logic [CNT_W-1:0]  drop_count,
`endif
   input  logic              cnt_clr
);

   typedef enum logic {ARB, LOCK} state_t;

   state_t       state;
   logic [2:0]   rr_ptr;
   logic [2:0]   lock_owner;

   logic         arb_hit;
   logic [2:0]   arb_win;
   logic [2:0]   win;
   logic [NUM_REQ-1:0] ready_c;
   logic         accept;
   logic         clip;
   logic [7:0]   sel_x;
   logic [6:0]   sel_y;
   logic [2:0]   sel_colour;
   logic         sel_lock;
   logic [2:0]   next_ptr;

   // Two passes give the wrap-around search from rr_ptr without a modulo on the index.
   always_comb begin
      arb_hit = 1'b0;
      arb_win = 3'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!arb_hit && bus.req_valid[i] && (3'(i) >= rr_ptr)) begin
            arb_hit = 1'b1;
            arb_win = 3'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!arb_hit && bus.req_valid[i] && (3'(i) < rr_ptr)) begin
            arb_hit = 1'b1;
            arb_win = 3'(i);
         end
      end
   end

   always_comb begin
      ready_c = '0;
      win     = (state == LOCK) ? lock_owner : arb_win;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rst) begin
            if (state == LOCK)
               ready_c[i] = (lock_owner == 3'(i)) && bus.req_valid[i];
            else
               ready_c[i] = arb_hit && (arb_win == 3'(i));
         end
      end
      accept = |ready_c;
   end

   assign bus.req_ready = ready_c;

   always_comb begin
      sel_x      = 8'd0;
      sel_y      = 7'd0;
      sel_colour = 3'd0;
      sel_lock   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == 3'(i)) begin
            sel_x      = bus.req_x[8*i +: 8];
            sel_y      = bus.req_y[7*i +: 7];
            sel_colour = bus.req_colour[3*i +: 3];
            sel_lock   = bus.req_lock[i];
         end
      end
`ifdef VGA_ARB_CLIP_EN
      clip = (sel_x >= 8'd160) || (sel_y >= 7'd120);
`else
      clip = 1'b0;
`endif
      next_ptr = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ARB;
         rr_ptr         <= 3'd0;
         lock_owner     <= 3'd0;
         grant_id       <= 3'd0;
         bus.vga_x      <= 8'd0;
         bus.vga_y      <= 7'd0;
         bus.vga_colour <= 3'd0;
         bus.vga_plot   <= 1'b0;
         plot_count     <= '0;
`ifdef VGA_ARB_CLIP_EN
         drop_count     <= '0;
`endif
      end else begin
         bus.vga_plot <= accept && !clip;
         if (accept) begin
            bus.vga_x      <= sel_x;
            bus.vga_y      <= sel_y;
            bus.vga_colour <= sel_colour;
            grant_id       <= win;
            rr_ptr         <= next_ptr;
         end

         // In LOCK, win is the owner, so sel_lock is the owner's lock even while it is idle.
         case (state)
            ARB: begin
               if (accept && sel_lock) begin
                  state      <= LOCK;
                  lock_owner <= win;
               end
            end
            LOCK: begin
               if (!sel_lock)
                  state <= ARB;
            end
            default: state <= ARB;
         endcase

         if (cnt_clr)
            plot_count <= '0;
         else if (accept && !clip && (plot_count != '1))
            plot_count <= plot_count + 1'b1;
`ifdef VGA_ARB_CLIP_EN
         if (cnt_clr)
            drop_count <= '0;
         else if (accept && clip && (drop_count != '1))
            drop_count <= drop_count + 1'b1;
`endif
      end
   end

endmodule
